// File: rtl/dat_rx_block_framer.sv
// Receive framer for one SD DAT line: start-bit search, MSB-first deserialise, CRC16/end-bit check (CRC logic only with DAT_RX_CRC_CHECK_EN).
// Latency: word strobe the cycle after its last bit; done one cycle after the final end bit.
// Backpressure: none toward the card; a word completing while fifo_full=1 is dropped and flags overrun.
module dat_rx_block_framer #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           blocks,
    input  logic [TIMEOUT_W-1:0] TIMEOUT_REG,
    input  logic                 dat_in,
    input  logic                 fifo_full,
    output logic [WORD_W-1:0]    dataToFIFO,
    output logic                 write_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_error,
    output logic                 end_error,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int BLOCK_BITS = BLOCK_BYTES * 8;
    localparam int BIT_W      = $clog2(BLOCK_BITS);
    localparam int WSEL_W     = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BLOCK_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [3:0]            crc_cnt;
    logic [TIMEOUT_W-1:0]  tmo_cnt;
    logic [TIMEOUT_W-1:0]  tmo_nxt;
    logic                  tmo_hit;
    logic [3:0]            blk_cnt;
    logic [WORD_W-2:0]     shift_dat;
    logic                  word_vld;
    logic                  word_end;

    assign tmo_nxt  = tmo_cnt + 1'b1;
    assign tmo_hit  = (TIMEOUT_REG != '0) && (tmo_nxt == TIMEOUT_REG);
    assign word_end = (bit_cnt[WSEL_W-1:0] == {WSEL_W{1'b1}});

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        done         = (state == DONE);
        // the FIFO push is qualified by the full flag of the strobe cycle itself
        write_enable = word_vld & ~fifo_full;
        case (state)
            IDLE:       if (start) state_nxt = WAIT_START;
            WAIT_START: begin
                if (!dat_in) begin
                    state_nxt = DATA;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DATA:       if (bit_cnt == LAST_BIT) state_nxt = CRC;
            CRC:        if (crc_cnt == 4'd15) state_nxt = END_BIT;
            END_BIT:    state_nxt = (blk_cnt == 4'd1) ? DONE : WAIT_START;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            crc_cnt    <= '0;
            tmo_cnt    <= '0;
            blk_cnt    <= '0;
            shift_dat  <= '0;
            word_vld   <= 1'b0;
            dataToFIFO <= '0;
            end_error  <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (word_vld && fifo_full) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        end_error <= 1'b0;
                        overrun   <= 1'b0;
                        timeout   <= 1'b0;
                        blk_cnt   <= (blocks == 4'd0) ? 4'd1 : blocks;
                        tmo_cnt   <= '0;
                    end
                end
                WAIT_START: begin
                    if (!dat_in) begin
                        bit_cnt <= '0;
                        crc_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    shift_dat <= {shift_dat[WORD_W-3:0], dat_in};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (word_end) begin
                        dataToFIFO <= {shift_dat, dat_in};
                        word_vld   <= 1'b1;
                    end
                end
                CRC: begin
                    crc_cnt <= crc_cnt + 1'b1;
                end
                END_BIT: begin
                    if (!dat_in) begin
                        end_error <= 1'b1;
                    end
                    blk_cnt <= blk_cnt - 1'b1;
                    tmo_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef DAT_RX_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [14:0] crc_rx;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            crc_calc  <= '0;
            crc_rx    <= '0;
            crc_error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) crc_error <= 1'b0;
                WAIT_START: if (!dat_in) crc_calc <= '0;
                DATA: crc_calc <= crc16_step(crc_calc, dat_in);
                CRC: begin
                    crc_rx <= {crc_rx[13:0], dat_in};
                    if ((crc_cnt == 4'd15) && ({crc_rx, dat_in} != crc_calc)) begin
                        crc_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_dat_rx_block_framer.sv
// Directed bench for dat_rx_block_framer with 8-byte blocks; words captured on the falling edge.
module tb_dat_rx_block_framer;

    localparam int WORD_W = 32;
`ifdef DAT_RX_CRC_CHECK_EN
    localparam logic EXP_CRC_ERR = 1'b1;
`else
    localparam logic EXP_CRC_ERR = 1'b0;
`endif

    logic              sd_clock = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        blocks;
    logic [15:0]       TIMEOUT_REG;
    logic              dat_in;
    logic              fifo_full;
    logic [WORD_W-1:0] dataToFIFO;
    logic              write_enable;
    logic              busy;
    logic              done;
    logic              crc_error;
    logic              end_error;
    logic              overrun;
    logic              timeout;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    dat_rx_block_framer #(.WORD_W(32), .BLOCK_BYTES(8), .TIMEOUT_W(16)) dut (
        .sd_clock(sd_clock), .reset(reset), .start(start), .blocks(blocks),
        .TIMEOUT_REG(TIMEOUT_REG), .dat_in(dat_in), .fifo_full(fifo_full),
        .dataToFIFO(dataToFIFO), .write_enable(write_enable), .busy(busy),
        .done(done), .crc_error(crc_error), .end_error(end_error),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 sd_clock = ~sd_clock;

    always @(negedge sd_clock) begin
        if (write_enable) got_q.push_back(dataToFIFO);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [63:0] d);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic send_bit(input logic b);
        dat_in = b;
        @(posedge sd_clock);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] nb, input logic [15:0] tmo);
        blocks = nb;
        TIMEOUT_REG = tmo;
        start = 1'b1;
        @(posedge sd_clock);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    // full_until: fifo_full is held high while data bit index <= full_until
    task automatic send_block(input logic [63:0] pl, input logic flip, input logic eb, input int full_until);
        logic [15:0] c;
        c = crc16(pl);
        if (flip) c[0] = ~c[0];
        send_bit(1'b0);
        for (int i = 0; i < 64; i++) begin
            fifo_full = (i <= full_until);
            send_bit(pl[63-i]);
        end
        fifo_full = 1'b0;
        check("we_first_crc_cycle", write_enable, 1'b1);
        check("last_word_dat", dataToFIFO, pl[31:0]);
        for (int i = 0; i < 16; i++) send_bit(c[15-i]);
        send_bit(eb);
    endtask

    task automatic check_words();
        check("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check("word_val", got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        blocks = 4'd1;
        TIMEOUT_REG = 16'd0;
        dat_in = 1'b1;
        fifo_full = 1'b0;
        repeat (2) @(posedge sd_clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_we", write_enable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dat", dataToFIFO, 32'h0);
        check("rst_flags", {crc_error, end_error, overrun, timeout}, 4'b0000);
        reset = 1'b1;
        repeat (2) send_bit(1'b1);

        // 1: single good block, then start offered in the DONE cycle
        clear_log();
        pulse_start(4'd1, 16'd1000);
        send_block(64'hDEADBEEF_01234567, 1'b0, 1'b1, -1);
        check("t1_done_latency", done, 1'b1);
        start = 1'b1;
        send_bit(1'b1);
        start = 1'b0;
        check("t1_done_one_cycle", done, 1'b0);
        check("t1_start_in_done_ignored", busy, 1'b0);
        send_bit(1'b1);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h01234567);
        check_words();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_flags", {crc_error, end_error, overrun, timeout}, 4'b0000);

        // 2: two blocks, second CRC corrupted
        clear_log();
        pulse_start(4'd2, 16'd0);
        send_block(64'h11223344_55667788, 1'b0, 1'b1, -1);
        check("t2_busy_between", busy, 1'b1);
        check("t2_no_early_done", done, 1'b0);
        repeat (3) send_bit(1'b1);
        send_block(64'hCAFEF00D_0BADC0DE, 1'b1, 1'b1, -1);
        check("t2_done", done, 1'b1);
        repeat (2) send_bit(1'b1);
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'h55667788);
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h0BADC0DE);
        check_words();
        check("t2_crc_error", crc_error, EXP_CRC_ERR);
        check("t2_end_error", end_error, 1'b0);
        check("t2_done_cnt", done_cnt, 1);

        // 3: start-bit timeout
        clear_log();
        pulse_start(4'd1, 16'd100);
        n = 0;
        while (n < 300 && !done) begin
            send_bit(1'b1);
            n++;
        end
        check("t3_cycles_to_done", n, 100);
        check("t3_timeout", timeout, 1'b1);
        send_bit(1'b1);
        check("t3_idle", busy, 1'b0);
        check("t3_no_writes", got_q.size(), 0);
        check("t3_done_cnt", done_cnt, 1);

        // 4: fifo full across the first word's strobe
        clear_log();
        pulse_start(4'd1, 16'd0);
        check("t4_timeout_cleared", timeout, 1'b0);
        send_block(64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1, 40);
        repeat (2) send_bit(1'b1);
        exp_q.push_back(32'h5A5A5A5A);
        check_words();
        check("t4_overrun", overrun, 1'b1);
        check("t4_crc_error", crc_error, 1'b0);
        check("t4_done_cnt", done_cnt, 1);

        // 5: blocks=0 acts as 1, bad end bit
        clear_log();
        pulse_start(4'd0, 16'd0);
        check("t5_overrun_cleared", overrun, 1'b0);
        send_block(64'h00000000_FFFFFFFF, 1'b0, 1'b0, -1);
        check("t5_done", done, 1'b1);
        repeat (2) send_bit(1'b1);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'hFFFFFFFF);
        check_words();
        check("t5_end_error", end_error, 1'b1);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_idle", busy, 1'b0);

        // 6: reset during DATA, then a clean block
        clear_log();
        pulse_start(4'd1, 16'd0);
        send_bit(1'b0);
        for (int i = 0; i < 40; i++) send_bit(i[0]);
        reset = 1'b0;
        #1;
        check("t6_busy_in_reset", busy, 1'b0);
        check("t6_we_in_reset", write_enable, 1'b0);
        check("t6_dat_in_reset", dataToFIFO, 32'h0);
        check("t6_flags_in_reset", {crc_error, end_error, overrun, timeout}, 4'b0000);
        repeat (3) send_bit(1'b1);
        reset = 1'b1;
        repeat (2) send_bit(1'b1);
        check("t6_no_done", done_cnt, 0);
        check("t6_no_partial_write", got_q.size(), 1);
        got_q.delete();
        pulse_start(4'd1, 16'd0);
        send_block(64'h13579BDF_2468ACE0, 1'b0, 1'b1, -1);
        repeat (2) send_bit(1'b1);
        exp_q.push_back(32'h13579BDF);
        exp_q.push_back(32'h2468ACE0);
        check_words();
        check("t6_flags", {crc_error, end_error, overrun, timeout}, 4'b0000);
        check("t6_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
